data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 i_clk  in  1  single clock; all state updates on rising edge.
REQ-002 i_rst_n  in  1  reset, synchronous, active-low.
REQ-003 i_req  in  2  per-port access request; bit 0 = core, bit 1 = DMA.
REQ-004 i_we  in  2  per-port direction: 1 = write, 0 = read.
REQ-005 i_addr0 / i_addr1  in  10 each  per-port byte address.
REQ-006 i_wdata0 / i_wdata1  in  8 each  per-port write data.
REQ-007 o_gnt  out  2  one-hot grant; command accepted this cycle.
REQ-008 o_rvalid  out  2  one-hot read-data-valid, per port.
REQ-009 o_rdata  out  8  read data, shared by both ports.
REQ-010 o_init_done  out  1  high once the memory clear sweep has completed.
REQ-011 o_mem_addr  out  10  address to the data memory.
REQ-011a o_mem_wdata  out  8  write data to the data memory.
REQ-011b o_mem_we / o_mem_re  out  1 each  write / read enables to the data memory.
REQ-012 i_mem_rdata  in  8  data memory output; valid on the cycle after o_mem_re.

Function
REQ-013 Arbiter states: INIT and RUN; reset enters INIT.
REQ-014 INIT: 10-bit counter walks 0..1023; each cycle drives o_mem_we=1, o_mem_addr=counter, o_mem_wdata=0; o_gnt=0.
REQ-015 INIT exits to RUN on the edge after the address-1023 write: 1024 write cycles; o_init_done registered high from the first RUN cycle.
REQ-016 RUN, both ports idle: o_mem_we=0, o_mem_re=0, o_mem_addr=0, o_mem_wdata=0.
REQ-017 RUN, single requester: o_gnt asserted combinationally in the same cycle as the request.
- Memory command (we/re, addr, wdata) driven from that port in the same cycle.
REQ-018 RUN, both requesting: round-robin between the ports.
- The port not granted most recently wins.
- Pointer updates only on a grant.
- Reset value of the pointer favours port 0.
REQ-019 At most one o_gnt bit per cycle; one memory access per cycle; back-to-back grants allowed with no bubble.
REQ-020 Requester holds i_req, i_we, addr and wdata stable until it sees o_gnt. i_req is deasserted or re-presented with a new command in the cycle after the grant.
REQ-021 Read granted in cycle N -> o_rvalid[port]=1 in cycle N+1 (registered), with o_rdata=i_mem_rdata.
- o_rdata=0 whenever o_rvalid=0.
REQ-022 Write granted in cycle N, read of the same address granted in cycle N+1 -> returns the new data at N+2. No forwarding is needed; memory order is preserved.
REQ-023 Requests during INIT are ignored (no grant) and remain pending; first grant is possible in the first RUN cycle.

Reset
REQ-024 i_rst_n low at a clock edge:
- state=INIT, counter=0, pointer=port 0, o_rvalid=0, o_init_done=0.
REQ-025 While i_rst_n is low:
- o_gnt, o_mem_we, o_mem_re, o_mem_addr and o_mem_wdata are forced to 0 combinationally.
REQ-026 Reset mid-INIT restarts the sweep from address 0.
- Reset in RUN drops any pending o_rvalid and reruns the full sweep.

Structure
REQ-027 Shared package data_memory_pkg holds:
- DM_ADDR_W=10, DM_DATA_W=8, DM_DEPTH=1024.
- Port-count constant DM_PORTS=2.
- Enum dm_arb_state_t {INIT, RUN}.
REQ-028 One sub-module, dm_rr_arbiter: 2-request round-robin grant plus pointer register. The FSM, counter and muxing stay in the top module.

Verification
REQ-029 Release reset -> 1024 consecutive cycles with o_mem_we=1 and addresses 0..1023, wdata 0; o_init_done=1 in the next cycle; no o_gnt throughout.
REQ-030 After init: core writes 0xA5 at 0x3FF, then reads 0x3FF -> gnt in each request cycle; o_rvalid[0]=1 with o_rdata=0xA5 one cycle after the read grant.
REQ-031 Both ports hold read requests for 6 cycles -> grants alternate 0,1,0,1,0,1; each o_rvalid follows its grant by one cycle.
REQ-032 DMA request raised at cycle 100 of INIT -> no grant until the first RUN cycle, then gnt[1] immediately.
REQ-033 Assert i_rst_n=0 at sweep address 500 for one cycle -> o_mem_we=0 in that cycle; the sweep restarts at address 0 and takes the full 1024 cycles; o_init_done stays 0.
REQ-034 Read granted, then reset in the next cycle -> o_rvalid stays 0 and o_rdata=0.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared sizes and state encoding for the data memory arbiter.
package data_memory_pkg;
  localparam int DM_ADDR_W = 10;
  localparam int DM_DATA_W = 8;
  localparam int DM_DEPTH  = 1024;
  localparam int DM_PORTS  = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dm_arb_state_t;
endpackage

// File: rtl/dm_rr_arbiter.sv
// Two-requester round-robin arbiter; the port not granted most recently wins a tie.
module dm_rr_arbiter
  import data_memory_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DM_PORTS-1:0] i_req,
  output logic [DM_PORTS-1:0] o_gnt
);

  // prio_q = 1 means port 1 is favoured on the next tie
  logic prio_q, prio_d;

  always_comb begin
    o_gnt  = i_req;
    if (i_req == 2'b11) o_gnt = prio_q ? 2'b10 : 2'b01;
    prio_d = prio_q;
    if (|o_gnt) prio_d = o_gnt[0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Core/DMA data memory arbiter: clears the memory after reset, then grants one access per cycle.
module data_memory_arbiter
  import data_memory_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [1:0]           i_req,
  input  logic [1:0]           i_we,
  input  logic [9:0]           i_addr0,
  input  logic [9:0]           i_addr1,
  input  logic [7:0]           i_wdata0,
  input  logic [7:0]           i_wdata1,
  output logic [1:0]           o_gnt,
  output logic [1:0]           o_rvalid,
  output logic [7:0]           o_rdata,
  output logic                 o_init_done,
  output logic [9:0]           o_mem_addr,
  output logic [7:0]           o_mem_wdata,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  input  logic [7:0]           i_mem_rdata
);

  dm_arb_state_t          state_q, state_d;
  logic [DM_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DM_PORTS-1:0]    rvalid_q, rvalid_d;
  logic                   init_done_q, init_done_d;
  logic [DM_PORTS-1:0]    arb_req, arb_gnt;

  // Requests are invisible to the arbiter until the sweep is done, so they stay pending
  assign arb_req = (i_rst_n && state_q == RUN) ? i_req : '0;

  dm_rr_arbiter u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (arb_req),
    .o_gnt   (arb_gnt)
  );

  always_comb begin
    o_gnt       = arb_gnt;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_rst_n) begin
      if (state_q == INIT) begin
        o_mem_we   = 1'b1;
        o_mem_addr = cnt_q;
      end else if (arb_gnt[0]) begin
        o_mem_we    = i_we[0];
        o_mem_re    = ~i_we[0];
        o_mem_addr  = i_addr0;
        o_mem_wdata = i_wdata0;
      end else if (arb_gnt[1]) begin
        o_mem_we    = i_we[1];
        o_mem_re    = ~i_we[1];
        o_mem_addr  = i_addr1;
        o_mem_wdata = i_wdata1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rvalid_d    = '0;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DM_ADDR_W'(DM_DEPTH - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN:     rvalid_d = arb_gnt & ~i_we;
      default: state_d  = INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rvalid_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      init_done_q <= init_done_d;
    end
  end

  // A read completing while reset is asserted is discarded, not returned
  assign o_rvalid    = i_rst_n ? rvalid_q : '0;
  assign o_rdata     = (|o_rvalid) ? i_mem_rdata : '0;
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed + randomized bench for data_memory_arbiter against a behavioural model.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, we, gnt, rvalid;
  logic [9:0] addr0, addr1, mem_addr;
  logic [7:0] wd0, wd1, rdata, mem_wdata, mem_rdata_q;
  logic       init_done, mem_we, mem_re;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wd0), .i_wdata1(wd1),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_init_done(init_done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .o_mem_re(mem_re), .i_mem_rdata(mem_rdata_q)
  );

  // Environment: synchronous RAM with one-cycle read latency
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata_q <= mem[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  // Behavioural model: expected memory contents, last granted port, pending read return
  logic [7:0] shadow [1024];
  int         last_gnt;
  logic [1:0] exp_rv, nxt_rv, last_eg;
  logic [7:0] exp_rd, nxt_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    exp_rv = nxt_rv;
    exp_rd = nxt_rd;
    nxt_rv = 2'b00;
    nxt_rd = 8'h00;
  endtask

  task automatic check_reset();
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    last_gnt = 1;
    nxt_rv = 2'b00;
    nxt_rd = 8'h00;
  endtask

  task automatic check_init(input int idx);
    #3;
    chk("init_we", mem_we, 1);
    chk("init_re", mem_re, 0);
    chk("init_addr", mem_addr, idx);
    chk("init_wdata", mem_wdata, 0);
    chk("init_gnt", gnt, 0);
    chk("init_done_lo", init_done, 0);
    chk("init_rvalid", rvalid, 0);
    chk("init_rdata", rdata, 0);
    shadow[idx] = 8'h00;
  endtask

  task automatic check_run();
    logic [1:0] eg;
    int p;
    logic [9:0] a;
    logic [7:0] d;
    #3;
    if (req == 2'b11) eg = (last_gnt == 0) ? 2'b10 : 2'b01;
    else              eg = req;
    last_eg = eg;
    chk("run_gnt", gnt, eg);
    chk("run_done", init_done, 1);
    chk("run_rvalid", rvalid, exp_rv);
    chk("run_rdata", rdata, exp_rd);
    if (eg == 2'b00) begin
      chk("idle_we", mem_we, 0);
      chk("idle_re", mem_re, 0);
      chk("idle_addr", mem_addr, 0);
      chk("idle_wdata", mem_wdata, 0);
    end else begin
      p = eg[1] ? 1 : 0;
      a = p ? addr1 : addr0;
      d = p ? wd1 : wd0;
      chk("cmd_we", mem_we, we[p]);
      chk("cmd_re", mem_re, !we[p]);
      chk("cmd_addr", mem_addr, a);
      chk("cmd_wdata", mem_wdata, d);
      last_gnt = p;
      if (we[p]) shadow[a] = d;
      else begin
        nxt_rv = eg;
        nxt_rd = shadow[a];
      end
    end
  endtask

  task automatic sweep(input int dma_at);
    for (int i = 0; i < 1024; i++) begin
      if (i == dma_at) begin
        req = 2'b10; we = 2'b00; addr1 = 10'd5;
      end
      check_init(i);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0; req = 0; we = 0; addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;
    last_gnt = 1; nxt_rv = 0; nxt_rd = 0; exp_rv = 0; exp_rd = 0; last_eg = 0;

    repeat (2) begin tick(); check_reset(); end
    tick();
    rst_n = 1'b1;

    // Full sweep with a DMA read raised mid-sweep; it must win the first RUN cycle
    sweep(100);
    check_run();
    chk("dma_first_gnt", gnt, 2'b10);
    tick(); req = 2'b00;
    check_run();
    chk("dma_rvalid", rvalid, 2'b10);

    // Core write then read of the top address
    tick(); req = 2'b01; we = 2'b01; addr0 = 10'h3FF; wd0 = 8'hA5;
    check_run();
    tick(); we = 2'b00;
    check_run();
    tick(); req = 2'b00;
    check_run();
    chk("core_rvalid", rvalid, 2'b01);
    chk("core_rdata", rdata, 8'hA5);

    // DMA write so the core is favoured next, then six cycles of contention
    tick(); req = 2'b10; we = 2'b10; addr1 = 10'd7; wd1 = 8'h3C;
    check_run();
    tick(); req = 2'b11; we = 2'b00; addr0 = 10'd7; addr1 = 10'h3FF;
    for (int k = 0; k < 6; k++) begin
      check_run();
      chk("alt_gnt", gnt, (k % 2) ? 2'b10 : 2'b01);
      tick();
    end
    req = 2'b00;
    check_run();
    chk("alt_last_rv", rvalid, 2'b10);
    chk("alt_last_rd", rdata, 8'hA5);

    // Random traffic over a small address window to force read-after-write hits
    for (int c = 0; c < 300; c++) begin
      tick();
      if (!(req[0] && !last_eg[0])) begin
        req[0] = ($urandom_range(0, 3) != 0);
        we[0]  = 1'($urandom);
        addr0  = 10'($urandom_range(0, 15));
        wd0    = 8'($urandom);
      end
      if (!(req[1] && !last_eg[1])) begin
        req[1] = ($urandom_range(0, 3) != 0);
        we[1]  = 1'($urandom);
        addr1  = 10'($urandom_range(0, 15));
        wd1    = 8'($urandom);
      end
      check_run();
    end

    // Reset at sweep address 500 restarts the whole sweep
    tick(); req = 2'b00; rst_n = 1'b0;
    check_reset();
    tick(); rst_n = 1'b1;
    for (int i = 0; i <= 500; i++) begin
      if (i == 500) begin
        rst_n = 1'b0;
        check_reset();
        chk("mid_sweep_done", init_done, 0);
      end else check_init(i);
      tick();
    end
    rst_n = 1'b1;
    sweep(-1);
    check_run();

    // Read granted, then reset in the following cycle: no read return
    tick(); req = 2'b01; we = 2'b00; addr0 = 10'd3;
    check_run();
    tick(); req = 2'b00; rst_n = 1'b0;
    check_reset();
    tick(); rst_n = 1'b1;
    check_init(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
